// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit family (divider today, multiplier later).
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int          DIV_ITERS      = 32;
    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    // Two's-complement negate when en is set, pass-through otherwise.
    function automatic logic [31:0] negate32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// result delivered as {HI = remainder, LO = quotient} with a one-cycle done pulse.
module hilo_div_unit
    import mdu_pkg::*;
#(
    parameter int ITERS = DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [63:0] hilo
);

    div_state_t  stateR;
    div_state_t  nextStateS;
    logic [4:0]  cntR;
    logic [32:0] remR;
    logic [31:0] dvdR;
    logic [31:0] divR;
    logic        signAR;
    logic        signBR;
    logic        signedR;
    logic [63:0] hiloR;

    logic        captureS;
    logic        stepS;
    logic        lastStepS;
    logic [33:0] remShiftS;
    logic [33:0] remDiffS;
    logic        qBitS;
    logic [32:0] remNextS;
    logic [31:0] quotNextS;
    logic [31:0] hiS;
    logic [31:0] loS;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next-state decode; flush overrides everything and freezes the datapath.
    always_comb begin
        nextStateS = stateR;
        captureS   = 1'b0;
        stepS      = 1'b0;
        lastStepS  = 1'b0;
        if (flush) begin
            nextStateS = IDLE;
        end else begin
            case (stateR)
                IDLE: begin
                    if (start) begin
                        captureS   = 1'b1;
                        nextStateS = BUSY;
                    end else begin
                        nextStateS = IDLE;
                    end
                end
                BUSY: begin
                    stepS = 1'b1;
                    if (cntR == 5'd0) begin
                        lastStepS  = 1'b1;
                        nextStateS = DONE;
                    end else begin
                        nextStateS = BUSY;
                    end
                end
                DONE: begin
                    // start is still the same instruction here, so it is ignored
                    nextStateS = IDLE;
                end
                default: begin
                    nextStateS = IDLE;
                end
            endcase
        end
    end

    // One restoring step; the borrow out of the wide subtract decides the quotient bit.
    always_comb begin
        remShiftS = {remR, dvdR[31]};
        remDiffS  = remShiftS - {2'b00, divR};
        qBitS     = ~remDiffS[33];
        if (qBitS) begin
            remNextS = remDiffS[32:0];
        end else begin
            remNextS = remShiftS[32:0];
        end
        quotNextS = {dvdR[30:0], qBitS};
    end

    // Sign fix-up of the final step; a zero divisor forces the all-ones quotient.
    always_comb begin
        hiS = negate32(remNextS[31:0], signedR & signAR);
        if (divR == 32'd0) begin
            loS = DIV_BY_ZERO_LO;
        end else begin
            loS = negate32(quotNextS, signedR & (signAR ^ signBR));
        end
    end

    // Operand capture and shift/subtract datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntR    <= 5'd0;
            remR    <= 33'd0;
            dvdR    <= 32'd0;
            divR    <= 32'd0;
            signAR  <= 1'b0;
            signBR  <= 1'b0;
            signedR <= 1'b0;
        end else if (captureS) begin
            cntR    <= 5'(ITERS - 1);
            remR    <= 33'd0;
            dvdR    <= negate32(a, signed_op & a[31]);
            divR    <= negate32(b, signed_op & b[31]);
            signAR  <= a[31];
            signBR  <= b[31];
            signedR <= signed_op;
        end else if (stepS) begin
            remR <= remNextS;
            dvdR <= quotNextS;
            if (cntR != 5'd0) begin
                cntR <= cntR - 5'd1;
            end else begin
                cntR <= cntR;
            end
        end
    end

    // Result register, loaded on the last step so it is valid throughout DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hiloR <= 64'd0;
        end else if (lastStepS) begin
            hiloR <= {hiS, loS};
        end
    end

    assign stall = ((stateR == IDLE) & start & ~flush) | (stateR == BUSY);
    assign done  = (stateR == DONE) & ~flush;
    assign hilo  = hiloR;

endmodule
